// File: rtl/fade_pkg.sv
// Shared types and helpers for the PWM fade engine: run modes, per-segment duty shapes,
// ramp direction encoding and the hue-segment to shape lookup.
package fade_pkg;

    typedef enum logic {
        MODE_HUE     = 1'b0,
        MODE_BREATHE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        SH_FULL,
        SH_FALL,
        SH_ZERO,
        SH_RISE
    } shape_e;

    localparam int unsigned NUM_SEG = 6;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Hue wheel: two segments full, one falling, two off, one rising.
    function automatic shape_e seg_shape(input logic [2:0] seg);
        shape_e sh;
        case (seg)
            3'd0, 3'd1: sh = SH_FULL;
            3'd2:       sh = SH_FALL;
            3'd3, 3'd4: sh = SH_ZERO;
            default:    sh = SH_RISE;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty compare against the shared period counter, channel mask and a
// glitch-free output register.
module pwm_channel #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] duty,
    input  logic         mask,
    output logic         pwm
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < duty) & mask;
        end
    end

endmodule

// File: rtl/pwm_fade_engine.sv
// Multi-channel PWM fader with hue-wheel and breathe sequencing.
// Define PWM_FADE_GAMMA_EN to apply a square-law gamma to each duty (one extra period of latency).
module pwm_fade_engine
    import fade_pkg::*;
#(
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned PWM_INTERVAL = 1200,
    parameter int unsigned DUTY_STEP    = 12,
    parameter int unsigned STEP_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick,
    output logic [2:0]        seg_out
);

    localparam int unsigned W  = $clog2(PWM_INTERVAL + 1);
    localparam int unsigned SW = $clog2(STEP_PERIODS + 1);

    localparam logic [W-1:0]  FULL      = W'(PWM_INTERVAL);
    localparam logic [W-1:0]  STEP      = W'(DUTY_STEP);
    localparam logic [W-1:0]  CNT_LAST  = W'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);

    if (DUTY_STEP == 0 || (PWM_INTERVAL % DUTY_STEP) != 0) begin : g_bad_step
        $error("PWM_INTERVAL must be a nonzero integer multiple of DUTY_STEP");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_nch
        $error("NUM_CH must be in 1..8");
    end

    logic [W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [W-1:0]  ramp_q, ramp_d;
    logic [2:0]    seg_q, seg_d;
    logic          dir_q, dir_d;
    mode_e         mode_q, mode_d;
    logic [W-1:0]  duty_q [NUM_CH];
    logic [W-1:0]  duty_d [NUM_CH];
    logic [W-1:0]  duty_eff [NUM_CH];

    logic          wrap;
    logic          fade_step;
    logic [W:0]    ramp_sum;
    logic [W-1:0]  ramp_up;
    logic [W-1:0]  ramp_dn;

    assign wrap        = (cnt_q == CNT_LAST);
    assign period_tick = wrap;
    assign seg_out     = seg_q;

    assign ramp_sum = {1'b0, ramp_q} + {1'b0, STEP};
    assign ramp_up  = (ramp_sum > {1'b0, FULL}) ? FULL : ramp_sum[W-1:0];
    assign ramp_dn  = (ramp_q < STEP) ? '0 : ramp_q - STEP;

    function automatic logic [W-1:0] chan_duty(input mode_e m, input logic [2:0] s,
                                               input logic [W-1:0] r, input int unsigned c);
        logic [2:0]   ls;
        logic [W-1:0] d;
        ls = 3'((32'(s) + 2 * c) % NUM_SEG);
        case (seg_shape(ls))
            SH_FULL: d = FULL;
            SH_FALL: d = FULL - r;
            SH_ZERO: d = '0;
            default: d = r;
        endcase
        if (m == MODE_BREATHE) begin
            d = r;
        end
        return d;
    endfunction

    always_comb begin
        cnt_d     = wrap ? '0 : cnt_q + W'(1);
        step_d    = step_q;
        ramp_d    = ramp_q;
        seg_d     = seg_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        fade_step = 1'b0;

        if (wrap) begin
            // A mode change restarts the sequencer and swallows any coincident fade step.
            if (mode_e'(mode) != mode_q) begin
                mode_d = mode_e'(mode);
                step_d = '0;
                ramp_d = '0;
                seg_d  = '0;
                dir_d  = DIR_UP;
            end else if (en) begin
                if (step_q == STEP_LAST) begin
                    step_d    = '0;
                    fade_step = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
        end

        if (fade_step) begin
            if (mode_q == MODE_HUE) begin
                if (ramp_q == FULL) begin
                    ramp_d = '0;
                    seg_d  = (seg_q == 3'(NUM_SEG - 1)) ? 3'd0 : seg_q + 3'd1;
                end else begin
                    ramp_d = ramp_up;
                end
            end else begin
                // Endpoints are held for one full step before the ramp turns around.
                if (dir_q == DIR_UP) begin
                    if (ramp_q == FULL) begin
                        dir_d  = DIR_DOWN;
                        ramp_d = ramp_dn;
                    end else begin
                        ramp_d = ramp_up;
                    end
                end else begin
                    if (ramp_q == '0) begin
                        dir_d  = DIR_UP;
                        ramp_d = ramp_up;
                    end else begin
                        ramp_d = ramp_dn;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            duty_d[c] = duty_q[c];
            if (wrap) begin
                duty_d[c] = chan_duty(mode_d, seg_d, ramp_d, c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            step_q <= '0;
            ramp_q <= '0;
            seg_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_HUE;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                duty_q[c] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            ramp_q <= ramp_d;
            seg_q  <= seg_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                duty_q[c] <= duty_d[c];
            end
        end
    end

`ifdef PWM_FADE_GAMMA_EN
    localparam int unsigned PW = 2 * W;

    logic [W-1:0] duty_eff_q [NUM_CH];

    // Sampled at the wrap, so the corrected duty trails the raw duty by one period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                duty_eff_q[c] <= '0;
            end
        end else if (wrap) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                duty_eff_q[c] <= W'((PW'(duty_q[c]) * PW'(duty_q[c])) / PW'(PWM_INTERVAL));
            end
        end
    end

    assign duty_eff = duty_eff_q;
`else
    assign duty_eff = duty_q;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pwm_channel #(
            .W(W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .cnt  (cnt_q),
            .duty (duty_eff[c]),
            .mask (ch_mask[c]),
            .pwm  (pwm_out[c])
        );
    end

endmodule

// File: tb/tb_pwm_fade_engine.sv
// Bench for pwm_fade_engine: per-period vector table with hand-derived duties, a per-cycle
// PWM scoreboard, plus async-reset and restart sequences.
module tb_pwm_fade_engine;

    localparam int unsigned NCH = 3;
    localparam int unsigned PI  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b1;
    logic           mode = 1'b0;
    logic [NCH-1:0] ch_mask = 3'b111;
    logic [NCH-1:0] pwm_out;
    logic           period_tick;
    logic [2:0]     seg_out;

    int checks = 0;
    int failures = 0;

    pwm_fade_engine #(
        .NUM_CH       (NCH),
        .PWM_INTERVAL (PI),
        .DUTY_STEP    (2),
        .STEP_PERIODS (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .ch_mask     (ch_mask),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .seg_out     (seg_out)
    );

    always #5 clk = ~clk;

    // Inputs for period r (driven mid-period) and the duties/segment expected during period r.
    typedef struct {
        logic       en;
        logic       mode;
        logic [2:0] mask;
        int         d0;
        int         d1;
        int         d2;
        logic [2:0] seg;
    } vec_t;

    vec_t         tbl[$];
    logic [2:0]   exp_q[$];

    task automatic row(input logic e, input logic m, input logic [2:0] msk,
                       input int d0, input int d1, input int d2, input logic [2:0] s);
        vec_t v;
        v.en = e; v.mode = m; v.mask = msk; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.seg = s;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int gam(input int d);
`ifdef PWM_FADE_GAMMA_EN
        return (d * d) / int'(PI);
`else
        return d;
`endif
    endfunction

    initial begin
        int prev[3];
        int eff[3];
        int cur[3];
        logic [2:0] e;

        // Hue wheel from reset
        row(1, 0, 3'b111, 0, 0, 0, 0);
        row(1, 0, 3'b111, 8, 6, 0, 0);
        row(1, 0, 3'b111, 8, 4, 0, 0);
        row(1, 0, 3'b111, 8, 2, 0, 0);
        row(1, 0, 3'b111, 8, 0, 0, 0);
        row(1, 0, 3'b111, 8, 0, 0, 1);
        row(1, 0, 3'b101, 8, 0, 2, 1);
        row(1, 0, 3'b101, 8, 0, 4, 1);
        row(1, 0, 3'b111, 8, 0, 6, 1);
        row(1, 0, 3'b111, 8, 0, 8, 1);
        row(1, 0, 3'b111, 8, 0, 8, 2);
        row(1, 0, 3'b111, 6, 0, 8, 2);
        // Switch to breathe mid-period: clear at the wrap, coincident step dropped
        row(1, 1, 3'b111, 4, 0, 8, 2);
        row(1, 1, 3'b111, 0, 0, 0, 0);
        row(1, 1, 3'b111, 2, 2, 2, 0);
        row(1, 1, 3'b111, 4, 4, 4, 0);
        row(1, 1, 3'b111, 6, 6, 6, 0);
        row(1, 1, 3'b111, 8, 8, 8, 0);
        row(1, 1, 3'b111, 6, 6, 6, 0);
        row(1, 1, 3'b010, 4, 4, 4, 0);
        row(1, 1, 3'b111, 2, 2, 2, 0);
        row(1, 1, 3'b111, 0, 0, 0, 0);
        row(1, 1, 3'b111, 2, 2, 2, 0);
        // en low across five wraps at duty 4
        row(0, 1, 3'b111, 4, 4, 4, 0);
        row(0, 1, 3'b111, 4, 4, 4, 0);
        row(0, 1, 3'b111, 4, 4, 4, 0);
        row(0, 1, 3'b111, 4, 4, 4, 0);
        row(0, 1, 3'b111, 4, 4, 4, 0);
        row(1, 1, 3'b111, 4, 4, 4, 0);
        row(1, 1, 3'b111, 6, 6, 6, 0);
        row(1, 1, 3'b111, 8, 8, 8, 0);
        // Back to hue: clear to ramp 0 / seg 0
        row(1, 0, 3'b111, 6, 6, 6, 0);
        row(1, 0, 3'b111, 8, 8, 0, 0);
        row(1, 0, 3'b111, 8, 6, 0, 0);

        prev = '{0, 0, 0};

        repeat (2) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_seg", int'(seg_out), 0);
        check("reset_tick", int'(period_tick), 0);
        rst = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            cur = '{tbl[r].d0, tbl[r].d1, tbl[r].d2};
            for (int c = 0; c < 3; c++) begin
                eff[c]  = gam(prev[c]);
                prev[c] = cur[c];
            end
`ifndef PWM_FADE_GAMMA_EN
            eff = cur;
`endif
            for (int k = 0; k < int'(PI); k++) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("pwm r%0d k%0d", r, k), int'(pwm_out), int'(e));
                end
                check($sformatf("tick r%0d k%0d", r, k), int'(period_tick), (k == int'(PI) - 1) ? 1 : 0);
                if (k == 4) begin
                    check($sformatf("seg r%0d", r), int'(seg_out), int'(tbl[r].seg));
                end
                if (k == 3) begin
                    en      = tbl[r].en;
                    mode    = tbl[r].mode;
                    ch_mask = tbl[r].mask;
                end
                for (int c = 0; c < 3; c++) begin
                    e[c] = (k < eff[c]) & ch_mask[c];
                end
                exp_q.push_back(e);
                @(negedge clk);
            end
        end

        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pwm final", int'(pwm_out), int'(e));
        end

        // Async reset mid-period while ch0 is high
        repeat (5) @(negedge clk);
        check("pre_reset_ch0_high", int'(pwm_out[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_seg", int'(seg_out), 0);
        check("async_reset_tick", int'(period_tick), 0);
        @(negedge clk);
        check("held_reset_pwm", int'(pwm_out), 0);
        rst = 1'b0;
        for (int i = 0; i < int'(PI); i++) begin
            check($sformatf("restart_tick %0d", i), int'(period_tick), (i == int'(PI) - 1) ? 1 : 0);
            check($sformatf("restart_pwm %0d", i), int'(pwm_out), 0);
            @(negedge clk);
        end
        check("restart_tick_clear", int'(period_tick), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
